// File: rtl/wor_arb_pkg.sv
// ----------------------------------------------------------------------------
// wor_arb_pkg
// Shared definitions for the wired-OR bus arbiter:
//   arb_state_t : FSM state encoding (IDLE / GRANT / TURN)
//   BEAT_W      : width of the per-grant beat counter
//   rr_next()   : round-robin pointer advance, wrapping modulo n
// ----------------------------------------------------------------------------
package wor_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_TURN  = 2'd2
    } arb_state_t;

    localparam int BEAT_W = 8;

    // Index that follows ptr in a ring of n requesters.
    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin picker. Scans req starting at rr_ptr and
// wrapping modulo N_REQ; the first set bit wins.
// Ports:
//   req    in   N_REQ   request vector
//   rr_ptr in   IW      index with highest priority this cycle
//   win    out  N_REQ   one-hot winner (all zero when no request)
//   idx    out  IW      index of the winner (0 when no request)
//   any    out  1       at least one request present
// ----------------------------------------------------------------------------
module rr_pick
    import wor_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    rr_ptr,
    output logic [N_REQ-1:0] win,
    output logic [IW-1:0]    idx,
    output logic             any
);

    int j;

    always_comb begin
        win = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            // rr_ptr is always < N_REQ, so one subtraction is enough to wrap
            j = int'(rr_ptr) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!any && req[j]) begin
                any    = 1'b1;
                win[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/wor_bus_arbiter.sv
// ----------------------------------------------------------------------------
// wor_bus_arbiter
// Round-robin controller sharing one wired-OR data bus among N_REQ requesters.
// Ownership is granted in bursts of up to MAX_BEAT beats, and TA_CYC idle
// turnaround cycles separate successive owners so two drivers never overlap.
// Ports:
//   clk       in   1               rising-edge clock
//   rst       in   1               synchronous reset, active-high
//   req       in   N_REQ           level request, held until granted
//   req_last  in   N_REQ           owner's final-beat marker (owner bit only)
//   gnt       out  N_REQ           one-hot grant, zero when no owner
//   drv_en    out  N_REQ           bus drive enable, equals gnt in GRANT
//   owner     out  $clog2(N_REQ)   current or most recent owner
//   busy      out  1               high in GRANT and TURN
//   beat_cnt  out  8               beats completed in the current grant
//   abort     out  1               1-cycle pulse on forced release
// ----------------------------------------------------------------------------
module wor_bus_arbiter
    import wor_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_BEAT = 8,
    parameter int TA_CYC   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         drv_en,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy,
    output logic [BEAT_W-1:0]        beat_cnt,
    output logic                     abort
);

    localparam int IW = $clog2(N_REQ);

    arb_state_t        state_q, state_d;
    logic [N_REQ-1:0]  gnt_q;
    logic [IW-1:0]     owner_q;
    logic [IW-1:0]     rr_ptr_q;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [1:0]        ta_q;
    logic              abort_q;

    logic              rel;
    logic              rel_abort;
    logic              own_req;
    logic              own_last;
    logic              beat_at_max;
    logic              ta_done;

    logic [N_REQ-1:0]  pick_win;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .win    (pick_win),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Only the owner's request/last bits matter while it holds the bus.
    assign own_req     = req[owner_q];
    assign own_last    = req_last[owner_q];
    assign beat_at_max = (beat_q == BEAT_W'(MAX_BEAT - 1));
    assign ta_done     = (int'(ta_q) >= TA_CYC - 1);

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        rel       = 1'b0;
        rel_abort = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                // A beat is counted only while the owner still requests.
                if (own_req && (beat_q != BEAT_W'(MAX_BEAT))) begin
                    beat_d = beat_q + BEAT_W'(1);
                end
                rel = own_last || !own_req || beat_at_max;
                // req_last turns a simultaneous MAX_BEAT hit into a normal end.
                rel_abort = !own_last && (!own_req || beat_at_max);
                if (rel) begin
                    state_d = (TA_CYC > 0) ? ARB_TURN : ARB_IDLE;
                end
            end
            ARB_TURN: begin
                if (ta_done) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            gnt_q    <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            beat_q   <= '0;
            ta_q     <= '0;
            abort_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            abort_q <= rel_abort;
            case (state_q)
                ARB_IDLE: begin
                    if (pick_any) begin
                        gnt_q   <= pick_win;
                        owner_q <= pick_idx;
                        beat_q  <= '0;
                    end
                end
                ARB_GRANT: begin
                    beat_q <= beat_d;
                    if (rel) begin
                        gnt_q    <= '0;
                        rr_ptr_q <= IW'(rr_next(int'(owner_q), N_REQ));
                        ta_q     <= '0;
                    end
                end
                ARB_TURN: begin
                    ta_q <= ta_q + 2'd1;
                end
                default: begin
                    gnt_q <= '0;
                end
            endcase
        end
    end

    assign gnt      = gnt_q;
    assign drv_en   = (state_q == ARB_GRANT) ? gnt_q : '0;
    assign owner    = owner_q;
    assign busy     = (state_q == ARB_GRANT) || (state_q == ARB_TURN);
    assign beat_cnt = beat_q;
    assign abort    = abort_q;

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst)
        $onehot0(gnt_q));
    a_drv_in_gnt : assert property (@(posedge clk) disable iff (rst)
        ((drv_en & ~gnt_q) == '0));
    a_gnt_iff_grant : assert property (@(posedge clk) disable iff (rst)
        ((gnt_q != '0) == (state_q == ARB_GRANT)));

endmodule
